// File: rtl/iter_div32.sv
// iter_div32: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock; signed mode divides magnitudes and fixes signs at the end.
module iter_div32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e           state_q;
    logic             sign_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             dz_q;
    logic [WIDTH-1:0] rem_q;   // partial remainder
    logic [WIDTH-1:0] dvd_q;   // working dividend, becomes the quotient magnitude
    logic [WIDTH-1:0] dvs_q;   // divisor magnitude
    logic [CNT_W-1:0] cnt_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes, one restoring trial step and the final sign fix-up.
    always_comb begin
        dvd_neg = Sign & dividend[WIDTH-1];
        dvs_neg = Sign & divisor[WIDTH-1];
        // -0x80000000 wraps back to 0x80000000, which read unsigned is exactly 2^31.
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        partial = {rem_q, dvd_q[WIDTH-1]};
        trial   = partial - {1'b0, dvs_q};
        q_fix   = (sign_q & (neg_a_q ^ neg_b_q)) ? -dvd_q : dvd_q;
        r_fix   = (sign_q & neg_a_q) ? -rem_q : rem_q;
    end

    // Control FSM together with the datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sign_q    <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            dz_q      <= 1'b0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sign_q  <= Sign;
                        neg_a_q <= dvd_neg;
                        neg_b_q <= dvs_neg;
                        rem_q   <= '0;
                        busy    <= 1'b1;
                        if (divisor == '0) begin
                            // Keep the raw dividend; it is returned as the remainder.
                            dz_q    <= 1'b1;
                            dvd_q   <= dividend;
                            dvs_q   <= '0;
                            // One extra FIN cycle so the result lands two edges after start.
                            cnt_q   <= CNT_W'(1);
                            state_q <= StFin;
                        end else begin
                            dz_q    <= 1'b0;
                            dvd_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            cnt_q   <= CNT_W'(WIDTH - 1);
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= partial[WIDTH-1:0];
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    if (dz_q && (cnt_q != '0)) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (dz_q) begin
                            quotient  <= '1;
                            remainder <= dvd_q;
                            div_zero  <= 1'b1;
                        end else begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                            div_zero  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
